// File: rtl/soc1_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them
// against compiled-in values. Define SOC1_SYSID_CHECK_TIMEOUT_EN to add a per-read timeout.
module soc1_sysid_checker #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1730297491,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  typedef enum logic [2:0] {StIdle, StRdId, StRdTs, StCheck, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] id_word_q, id_word_d, ts_word_q, ts_word_d;
  logic        pass_q, pass_d, id_mm_q, id_mm_d, ts_mm_q, ts_mm_d;
  logic        in_read, start_ok, tmo_hit;

  assign in_read  = (state_q == StRdId) || (state_q == StRdTs);
  assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef SOC1_SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  // Counter is zero whenever a read state is entered: it only survives stalled cycles.
  assign tmo_hit = in_read && avm_waitrequest && (cnt_q == TmoLast);

  always_comb begin
    cnt_d = '0;
    if (in_read && avm_waitrequest) cnt_d = cnt_q + 16'd1;
    tmo_d = tmo_q;
    if (start_ok) tmo_d = 1'b0;
    else if (tmo_hit) tmo_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    id_word_d = id_word_q;
    ts_word_d = ts_word_q;
    pass_d    = pass_q;
    id_mm_d   = id_mm_q;
    ts_mm_d   = ts_mm_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRdId;
          pass_d  = 1'b0;
          id_mm_d = 1'b0;
          ts_mm_d = 1'b0;
        end
      end
      StRdId, StRdTs: begin
        if (!avm_waitrequest) begin
          if (state_q == StRdId) begin
            id_word_d = avm_readdata;
            state_d   = StRdTs;
          end else begin
            ts_word_d = avm_readdata;
            state_d   = StCheck;
          end
        end else if (tmo_hit) begin
          state_d = StDone;
        end
      end
      StCheck: begin
        id_mm_d = (id_word_q != EXPECTED_ID);
        ts_mm_d = (ts_word_q != EXPECTED_TS);
        pass_d  = (id_word_q == EXPECTED_ID) && (ts_word_q == EXPECTED_TS);
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      id_word_q <= '0;
      ts_word_q <= '0;
      pass_q    <= 1'b0;
      id_mm_q   <= 1'b0;
      ts_mm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_word_q <= id_word_d;
      ts_word_q <= ts_word_d;
      pass_q    <= pass_d;
      id_mm_q   <= id_mm_d;
      ts_mm_q   <= ts_mm_d;
    end
  end

  // Decoded straight from the state register so reset drops avm_read without a clock edge.
  assign avm_read    = in_read;
  assign avm_address = (state_q == StRdTs) ? BASE_ADDR + 32'd4 : BASE_ADDR;
  assign busy        = in_read || (state_q == StCheck);
  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign id_mismatch = id_mm_q;
  assign ts_mismatch = ts_mm_q;
  assign id_word     = id_word_q;
  assign ts_word     = ts_word_q;

endmodule
